mux_pipe_stage: RTL and testbench
=================================

Name: mux_pipe_stage

Overview:
- Parametrised N-way operand select combined with a registered pipeline stage for the PCPU datapath.
- Generalises the fixed two-way and three-way 32-bit selects to WAYS inputs of WIDTH bits.
- Adds a valid/ready handshake with a 2-entry skid buffer, so in_ready is a register output and upstream stalls do not form a combinational path.
- Used between ID and EX for forwarded operands, where stall (downstream not ready) and flush (branch taken) must be honoured.

Parameters:
- WIDTH, 32: data width of each way and of the output.
- WAYS, 3: number of selectable inputs, legal range 2..16.
- SEL_W, derived localparam: max(1, clog2(WAYS)); width of the select. Not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush; discards all held entries.
- in_valid  in  1  upstream entry is valid.
- in_ready  out  1  stage can accept an entry this cycle; registered.
- in_sel  in  SEL_W  way select, sampled with the entry.
- in_data  in  WAYS*WIDTH  flattened ways; way i occupies [i*WIDTH +: WIDTH].
- out_valid  out  1  out_data holds a valid entry.
- out_ready  in  1  downstream accepts the entry.
- out_data  out  WIDTH  selected data; registered.
- occ  out  2  occupancy, 0..2.
- sel_err  out  1  sticky flag: an out-of-range select was accepted.
- err_clr  in  1  synchronous clear of sel_err.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, skid entry invalid, in_ready=1, occ=0, sel_err=0.
- Accept occurs on (in_valid && in_ready) at a rising edge. Selection happens at accept time: value = in_data way in_sel; if in_sel >= WAYS, value = 0.
- Latency: an entry accepted at edge N appears on out_valid/out_data after edge N (1 cycle) when the main register is empty or draining.
- Output fire is (out_valid && out_ready).
- Storage is a main register (drives out_*) plus one skid register. in_ready = !skid_valid, registered.
- Per-edge update, with flush not asserted:
  - Main empty or firing, skid empty: an accepted entry goes to main.
  - Main firing, skid full: skid moves to main. No accept is possible because in_ready=0.
  - Main full and not firing, accept: entry goes to skid, and in_ready drops at the next edge.
  - Main firing, no accept, skid empty: out_valid=0 at the next edge. out_data holds its last value.
- occ = out_valid + skid_valid. State sequence: EMPTY(0), ONE(1), FULL(2). Legal transitions are ±1 per cycle, or 1→1 on simultaneous accept and fire. 2→0 is reachable only by flush.
- Flush: at the edge, main and skid are invalidated, occ=0, and in_ready=1 next cycle. An entry offered in the same cycle is dropped and does not set sel_err. Flush takes priority over accept and fire.
- sel_err: set at the edge when an entry with in_sel >= WAYS is accepted. Cleared by err_clr. If set and clear coincide, set wins. When WAYS is a power of two, the out-of-range case cannot occur.
- out_data is not cleared by flush or by firing. Only reset zeroes it. Downstream qualifies with out_valid.
- No combinational path from out_ready or in_valid to in_ready.

Decomposition:
- Package pcpu_dp_pkg:
  - function sel_width(ways), giving max(1, clog2).
  - OCC_EMPTY/OCC_ONE/OCC_FULL constants.
  - default WIDTH=32.
- Combinational select is a sub-module mux_n_way (WIDTH, WAYS; out-of-range yields 0). It replaces the fixed two-way and three-way muxes elsewhere in the datapath.
- Skid control stays in mux_pipe_stage.

Test Plan:
- Reset then single transfer, WAYS=3: in_data ways {0x11,0x22,0x33}, sel=2, out_ready=1 → out_valid=1 and out_data=0x33 one cycle later; occ returns to 0 after fire.
- Back-to-back stream, out_ready=1: sels 0,1,2,0 on consecutive cycles → outputs 0x11,0x22,0x33,0x11 on consecutive cycles; in_ready stays 1.
- Backpressure: out_ready=0, offer 3 entries → first in main, second in skid, in_ready=0, third held upstream. Raise out_ready → entries emerge in order with no loss or duplicate; occ goes 2,1,… .
- Out-of-range select: sel=3 with WAYS=3 → out_data=0, sel_err=1 and stays 1 through later legal transfers. err_clr → 0. Simultaneous set and err_clr → 1.
- Flush at occ=2 with in_valid=1 in the same cycle → next cycle out_valid=0, occ=0, in_ready=1, offered entry lost, sel_err unchanged.
- Async reset mid-backpressure (occ=2): assert rst_n low between edges → outputs return to reset values immediately. After release, the first new transfer has 1-cycle latency.

Source files
------------

// File: rtl/pcpu_dp_pkg.sv
// Shared datapath definitions for the PCPU operand-select pipeline stages.
// Holds the default data width, occupancy encoding and select-width helper.
package pcpu_dp_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // A two-way select still needs one select bit, so clamp the width at 1.
    function automatic int sel_width(input int ways);
        return (ways <= 2) ? 1 : $clog2(ways);
    endfunction

endpackage

// File: rtl/mux_pipe_stage_if.sv
// Valid/ready handshake bundle for mux_pipe_stage: upstream entry side and
// downstream result side. The stage uses the slave view.
interface mux_pipe_stage_if
    import pcpu_dp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int WAYS  = 3
);
    localparam int SEL_W = sel_width(WAYS);

    logic                    in_valid;
    logic                    in_ready;
    logic [SEL_W-1:0]        in_sel;
    logic [WAYS*WIDTH-1:0]   in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;

    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/mux_n_way.sv
// Combinational WAYS-to-1 select of WIDTH-bit operands; a select beyond the
// last way yields zero and raises out_of_range.
module mux_n_way
    import pcpu_dp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int WAYS  = 3
) (
    input  logic [sel_width(WAYS)-1:0] sel,
    input  logic [WAYS*WIDTH-1:0]      data,
    output logic [WIDTH-1:0]           y,
    output logic                       out_of_range
);
    localparam int SEL_W = sel_width(WAYS);

    always_comb begin
        y            = '0;
        out_of_range = 1'b1;
        for (int i = 0; i < WAYS; i++) begin
            if (sel == SEL_W'(i)) begin
                y            = data[i*WIDTH +: WIDTH];
                out_of_range = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_pipe_stage.sv
// Registered N-way operand select with a 2-entry skid buffer, placed between
// ID and EX so forwarded operands honour stall and branch flush.
module mux_pipe_stage
    import pcpu_dp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int WAYS  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 err_clr,
    output logic [1:0]           occ,
    output logic                 sel_err,
    mux_pipe_stage_if.slave      bus
);
    logic             main_valid;
    logic [WIDTH-1:0] main_data;
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             in_ready_q;
    logic             sel_err_q;

    logic [WIDTH-1:0] sel_data;
    logic             sel_oor;
    logic             accept;
    logic             fire;

    logic             main_valid_nxt;
    logic             skid_valid_nxt;
    logic             main_load;
    logic             main_from_skid;
    logic             skid_load;
    occ_e             occ_state;

    mux_n_way #(
        .WIDTH (WIDTH),
        .WAYS  (WAYS)
    ) u_mux (
        .sel          (bus.in_sel),
        .data         (bus.in_data),
        .y            (sel_data),
        .out_of_range (sel_oor)
    );

    assign accept = bus.in_valid && in_ready_q && !flush;
    assign fire   = main_valid && bus.out_ready;

    // The skid entry always predates anything offered now, so it refills main first.
    always_comb begin
        main_valid_nxt = main_valid;
        skid_valid_nxt = skid_valid;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
            main_valid_nxt = 1'b0;
            skid_valid_nxt = 1'b0;
        end else if (!main_valid || fire) begin
            if (skid_valid) begin
                main_valid_nxt = 1'b1;
                main_from_skid = 1'b1;
                skid_valid_nxt = 1'b0;
            end else if (accept) begin
                main_valid_nxt = 1'b1;
                main_load      = 1'b1;
            end else begin
                main_valid_nxt = 1'b0;
            end
        end else if (accept) begin
            skid_valid_nxt = 1'b1;
            skid_load      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            in_ready_q <= 1'b1;
            sel_err_q  <= 1'b0;
        end else begin
            main_valid <= main_valid_nxt;
            skid_valid <= skid_valid_nxt;
            in_ready_q <= !skid_valid_nxt;
            if (main_from_skid) begin
                main_data <= skid_data;
            end else if (main_load) begin
                main_data <= sel_data;
            end
            if (skid_load) begin
                skid_data <= sel_data;
            end
            if (accept && sel_oor) begin
                sel_err_q <= 1'b1;
            end else if (err_clr) begin
                sel_err_q <= 1'b0;
            end
        end
    end

    always_comb begin
        occ_state = OCC_EMPTY;
        if (main_valid && skid_valid) begin
            occ_state = OCC_FULL;
        end else if (main_valid || skid_valid) begin
            occ_state = OCC_ONE;
        end
    end

    assign occ           = occ_state;
    assign sel_err       = sel_err_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = main_valid;
    assign bus.out_data  = main_data;

endmodule

// File: tb/tb_mux_pipe_stage.sv
// Scoreboard bench for mux_pipe_stage (WAYS=3): directed transfers, backpressure,
// out-of-range select, flush and asynchronous reset.
module tb_mux_pipe_stage;
    localparam int WIDTH = 32;
    localparam int WAYS  = 3;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       err_clr;
    logic [1:0] occ;
    logic       sel_err;

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];

    mux_pipe_stage_if #(.WIDTH(WIDTH), .WAYS(WAYS)) bus ();

    mux_pipe_stage #(
        .WIDTH (WIDTH),
        .WAYS  (WAYS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .err_clr (err_clr),
        .occ     (occ),
        .sel_err (sel_err),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Offer one entry and wait (bounded) for acceptance; the expected output is queued on accept.
    task automatic applyStimulus(input logic [1:0] sel, input logic [31:0] exp);
        int waited = 0;
        bus.in_sel   = sel;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL accept_timeout: in_ready stuck at 0 for sel %0d", sel);
        end else begin
            exp_q.push_back(exp);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready && !flush) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_out: got 0x%0h, expected no output", bus.out_data);
            end else begin
                checkOutput("out_data", bus.out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        err_clr       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sel    = '0;
        bus.in_data   = {32'h33, 32'h22, 32'h11};
        bus.out_ready = 1'b1;
        #12 rst_n = 1'b1;
        @(posedge clk); #1;

        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_out_data", bus.out_data, 32'd0);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_occ", 32'(occ), 32'd0);
        checkOutput("rst_sel_err", 32'(sel_err), 32'd0);

        $display("[TB] single transfer");
        applyStimulus(2'd2, 32'h33);
        checkOutput("latency_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("latency_occ", 32'(occ), 32'd1);
        @(posedge clk); #1;
        checkOutput("single_occ_drained", 32'(occ), 32'd0);

        $display("[TB] back-to-back stream");
        applyStimulus(2'd0, 32'h11);
        checkOutput("stream_in_ready0", 32'(bus.in_ready), 32'd1);
        applyStimulus(2'd1, 32'h22);
        checkOutput("stream_in_ready1", 32'(bus.in_ready), 32'd1);
        applyStimulus(2'd2, 32'h33);
        checkOutput("stream_in_ready2", 32'(bus.in_ready), 32'd1);
        applyStimulus(2'd0, 32'h11);
        checkOutput("stream_in_ready3", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;

        $display("[TB] backpressure");
        bus.out_ready = 1'b0;
        applyStimulus(2'd0, 32'h11);
        applyStimulus(2'd1, 32'h22);
        fork
            applyStimulus(2'd2, 32'h33);
            begin
                @(negedge clk);
                checkOutput("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
                checkOutput("bp_occ_full", 32'(occ), 32'd2);
                @(negedge clk);
                checkOutput("bp_occ_held", 32'(occ), 32'd2);
                @(posedge clk); #1;
                bus.out_ready = 1'b1;
                @(negedge clk);
                checkOutput("bp_occ_pre_fire", 32'(occ), 32'd2);
                @(negedge clk);
                checkOutput("bp_occ_after_fire", 32'(occ), 32'd1);
                checkOutput("bp_in_ready_back", 32'(bus.in_ready), 32'd1);
                @(negedge clk);
                checkOutput("bp_occ_accept_fire", 32'(occ), 32'd1);
                @(negedge clk);
                checkOutput("bp_occ_empty", 32'(occ), 32'd0);
            end
        join
        @(posedge clk); #1;

        $display("[TB] out-of-range select");
        applyStimulus(2'd3, 32'h0);
        checkOutput("oor_sel_err_set", 32'(sel_err), 32'd1);
        applyStimulus(2'd1, 32'h22);
        checkOutput("oor_sel_err_sticky", 32'(sel_err), 32'd1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        checkOutput("oor_sel_err_clr", 32'(sel_err), 32'd0);
        err_clr = 1'b1;
        applyStimulus(2'd3, 32'h0);
        err_clr = 1'b0;
        checkOutput("oor_set_beats_clr", 32'(sel_err), 32'd1);
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        checkOutput("oor_sel_err_clr2", 32'(sel_err), 32'd0);

        $display("[TB] flush at occ=2");
        bus.out_ready = 1'b0;
        applyStimulus(2'd0, 32'h11);
        applyStimulus(2'd1, 32'h22);
        checkOutput("fl_occ_before", 32'(occ), 32'd2);
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd2;
        @(posedge clk); #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        checkOutput("fl_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("fl_occ", 32'(occ), 32'd0);
        checkOutput("fl_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("fl_sel_err", 32'(sel_err), 32'd0);

        $display("[TB] flush at occ=1 with out-of-range offer");
        applyStimulus(2'd0, 32'h11);
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd3;
        @(posedge clk); #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        checkOutput("fl1_occ", 32'(occ), 32'd0);
        checkOutput("fl1_sel_err", 32'(sel_err), 32'd0);
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("fl_entry_lost", 32'(bus.out_valid), 32'd0);

        $display("[TB] async reset under backpressure");
        applyStimulus(2'd3, 32'h0);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        applyStimulus(2'd2, 32'h33);
        applyStimulus(2'd0, 32'h11);
        checkOutput("ar_occ_before", 32'(occ), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        checkOutput("ar_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("ar_out_data", bus.out_data, 32'd0);
        checkOutput("ar_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("ar_occ", 32'(occ), 32'd0);
        checkOutput("ar_sel_err", 32'(sel_err), 32'd0);
        #3 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        applyStimulus(2'd1, 32'h22);
        checkOutput("ar_latency_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;

        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
